// File: rtl/ii_port_arbiter.sv
// Port-A owner for the integral-image BRAM: sequences capture writes, cascade reads
// and the drain of in-flight reads once per frame, counting rejected capture writes.
module ii_port_arbiter #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 20,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_done,
  input  logic              go,
  input  logic              cls_rd_req,
  input  logic [ADDR_W-1:0] cls_rd_addr,
  output logic              cls_rd_gnt,
  output logic              cls_rd_valid,
  output logic [DATA_W-1:0] cls_rd_data,
  output logic              detect_en,
  input  logic              detect_done,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [2:0]        state_out,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    ST_ARM     = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DETECT  = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_din_q, bram_din_d;
  logic                detect_en_q, detect_en_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  // Bit k set means a read granted k+1 edges ago; the top bit is the read whose data is on bram_dout now.
  logic [RD_LATENCY:0] rd_vld_q, rd_vld_d;

  logic wr_fire;
  logic drop_hit;
  logic rd_gnt;
  logic rd_pending;

  assign wr_fire    = cap_we & (state_q == ST_CAPTURE);
  assign drop_hit   = cap_we & ((state_q == ST_HOLD) | (state_q == ST_DETECT) | (state_q == ST_DRAIN));
  assign rd_gnt     = cls_rd_req & (state_q == ST_DETECT) & ~detect_done;
  // Only reads still to arrive hold DRAIN; the one delivering data this cycle completes on its own.
  assign rd_pending = |rd_vld_q[RD_LATENCY-1:0];

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM:     if (frame_start) state_d = ST_CAPTURE;
      ST_CAPTURE: if (cap_done)    state_d = go ? ST_DETECT : ST_HOLD;
      ST_HOLD:    if (go)          state_d = ST_DETECT;
      ST_DETECT:  if (detect_done) state_d = ST_DRAIN;
      ST_DRAIN:   if (!rd_pending) state_d = ST_ARM;
      default:                     state_d = ST_ARM;
    endcase
  end

  always_comb begin
    bram_we_d   = wr_fire;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    if (wr_fire) begin
      bram_addr_d = cap_addr;
      bram_din_d  = cap_data;
    end else if (rd_gnt) begin
      bram_addr_d = cls_rd_addr;
    end

    detect_en_d = (state_d == ST_DETECT);
    rd_vld_d    = {rd_vld_q[RD_LATENCY-1:0], rd_gnt};

    drop_cnt_d = drop_cnt_q;
    if (drop_hit && (drop_cnt_q != {DROP_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ARM;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      detect_en_q <= 1'b0;
      drop_cnt_q  <= '0;
      rd_vld_q    <= '0;
    end else begin
      state_q     <= state_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      detect_en_q <= detect_en_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  assign cls_rd_gnt   = rd_gnt;
  assign cls_rd_valid = rd_vld_q[RD_LATENCY];
  assign cls_rd_data  = bram_dout;
  assign detect_en    = detect_en_q;
  assign bram_we      = bram_we_q;
  assign bram_addr    = bram_addr_q;
  assign bram_din     = bram_din_q;
  assign state_out    = state_q;
  assign drop_cnt     = drop_cnt_q;

  a_one_driver: assert property (@(posedge clk) disable iff (rst) !(wr_fire && rd_gnt));

endmodule

// File: tb/tb_ii_port_arbiter.sv
// Directed bench for ii_port_arbiter: table-driven capture vectors, then hand sequences
// for hold, read pipeline, drain, drop saturation and mid-detection reset.
module tb_ii_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start, cap_we, cap_done, go, cls_rd_req, detect_done;
  logic [AW-1:0] cap_addr, cls_rd_addr;
  logic [DW-1:0] cap_data;
  logic [DW-1:0] bram_dout;

  logic          gnt, valid, detect_en, bram_we;
  logic [DW-1:0] rd_data, bram_din;
  logic [AW-1:0] bram_addr;
  logic [2:0]    state;
  logic [7:0]    drop;

  logic          s_gnt, s_valid, s_detect_en, s_bram_we;
  logic [DW-1:0] s_rd_data, s_bram_din;
  logic [AW-1:0] s_bram_addr;
  logic [2:0]    s_state;
  logic [1:0]    s_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ii_port_arbiter dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cap_we(cap_we), .cap_addr(cap_addr),
    .cap_data(cap_data), .cap_done(cap_done), .go(go), .cls_rd_req(cls_rd_req),
    .cls_rd_addr(cls_rd_addr), .cls_rd_gnt(gnt), .cls_rd_valid(valid), .cls_rd_data(rd_data),
    .detect_en(detect_en), .detect_done(detect_done), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout), .state_out(state), .drop_cnt(drop)
  );

  ii_port_arbiter #(.DROP_W(2)) dut_s (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cap_we(cap_we), .cap_addr(cap_addr),
    .cap_data(cap_data), .cap_done(cap_done), .go(go), .cls_rd_req(cls_rd_req),
    .cls_rd_addr(cls_rd_addr), .cls_rd_gnt(s_gnt), .cls_rd_valid(s_valid), .cls_rd_data(s_rd_data),
    .detect_en(s_detect_en), .detect_done(detect_done), .bram_we(s_bram_we), .bram_addr(s_bram_addr),
    .bram_din(s_bram_din), .bram_dout(bram_dout), .state_out(s_state), .drop_cnt(s_drop)
  );

  // BRAM port-A model, two clocks from registered address to dout.
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] rd_p1;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rd_p1     = '0;
    bram_dout = '0;
  end
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr[4:0]] <= bram_din;
    rd_p1     <= mem[bram_addr[4:0]];
    bram_dout <= rd_p1;
  end

  typedef struct {
    logic          fs, we, done, go, ddone;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    e_state;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic fs, we, input int a, d, input logic done, go, ddone,
                              input int e_state, input logic e_we, input int e_addr, e_din);
    vec_t v;
    v.fs = fs; v.we = we; v.a = AW'(a); v.d = DW'(d);
    v.done = done; v.go = go; v.ddone = ddone;
    v.e_state = 3'(e_state); v.e_we = e_we; v.e_addr = AW'(e_addr); v.e_din = DW'(e_din);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    frame_start = 0; cap_we = 0; cap_addr = '0; cap_data = '0; cap_done = 0;
    go = 0; cls_rd_req = 0; cls_rd_addr = '0; detect_done = 0;
  endtask

  initial begin
    //         fs we  a   d    done go ddone  state we addr din
    vecs[0]  = mk(0, 1, 5, 55,   0, 0, 0,     0,   0, 0, 0);
    vecs[1]  = mk(0, 1, 6, 66,   0, 0, 0,     0,   0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0,    0, 0, 0,     1,   0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 10,   0, 0, 0,     1,   1, 0, 10);
    vecs[4]  = mk(0, 1, 1, 11,   0, 0, 0,     1,   1, 1, 11);
    vecs[5]  = mk(0, 1, 2, 12,   0, 0, 0,     1,   1, 2, 12);
    vecs[6]  = mk(0, 0, 0, 0,    0, 0, 0,     1,   0, 2, 12);
    vecs[7]  = mk(0, 1, 3, 13,   0, 0, 0,     1,   1, 3, 13);
    vecs[8]  = mk(1, 0, 0, 0,    0, 1, 1,     1,   0, 3, 13);
    vecs[9]  = mk(0, 1, 7, 1007, 0, 0, 0,     1,   1, 7, 1007);
    vecs[10] = mk(0, 1, 8, 1008, 0, 0, 0,     1,   1, 8, 1008);
    vecs[11] = mk(0, 1, 9, 1009, 1, 0, 0,     2,   1, 9, 1009);

    idle();
    rst = 1;
    repeat (3) step();
    rst = 0;
    check("reset state", 32'(state), 0);
    check("reset bram_we", 32'(bram_we), 0);
    check("reset bram_addr", 32'(bram_addr), 0);
    check("reset bram_din", 32'(bram_din), 0);
    check("reset valid", 32'(valid), 0);
    check("reset detect_en", 32'(detect_en), 0);
    check("reset drop", 32'(drop), 0);

    // Capture vectors: ignored writes in ARM, then a frame that ends in HOLD.
    for (int i = 0; i < 12; i++) begin
      frame_start = vecs[i].fs; cap_we = vecs[i].we; cap_addr = vecs[i].a; cap_data = vecs[i].d;
      cap_done = vecs[i].done; go = vecs[i].go; detect_done = vecs[i].ddone;
      step();
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].e_state));
      check($sformatf("vec%0d bram_we", i), 32'(bram_we), 32'(vecs[i].e_we));
      check($sformatf("vec%0d bram_addr", i), 32'(bram_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d bram_din", i), 32'(bram_din), 32'(vecs[i].e_din));
    end
    idle();
    check("arm writes not counted", 32'(drop), 0);

    // HOLD: 20 cycles, 5 rejected writes, a stray cap_done.
    for (int i = 0; i < 20; i++) begin
      cap_we = (i % 4 == 1); cap_addr = 15'd20; cap_data = 20'hABC; cap_done = (i == 10);
      step();
      check("hold state", 32'(state), 2);
      check("hold bram_we", 32'(bram_we), 0);
    end
    idle();
    check("hold drop", 32'(drop), 5);
    check("hold drop sat", 32'(s_drop), 3);
    go = 1;
    step();
    go = 0;
    check("go -> detect", 32'(state), 3);
    check("detect_en", 32'(detect_en), 1);

    cap_we = 1; cap_addr = 15'd21;
    step();
    cap_we = 0;
    check("detect drop", 32'(drop), 6);
    check("detect drop sat", 32'(s_drop), 3);
    check("detect bram_we", 32'(bram_we), 0);
    check("detect_en held", 32'(detect_en), 1);

    // Read pipeline: three back-to-back reads of words 7, 8, 9.
    for (int k = 0; k < 7; k++) begin
      cls_rd_req  = (k < 3);
      cls_rd_addr = AW'(7 + k);
      #1;
      check($sformatf("rd%0d gnt", k), 32'(gnt), (k < 3) ? 1 : 0);
      if (k >= 1 && k <= 3) check($sformatf("rd%0d bram_addr", k), 32'(bram_addr), 32'(6 + k));
      check($sformatf("rd%0d valid", k), 32'(valid), (k >= 3 && k <= 5) ? 1 : 0);
      if (k >= 3 && k <= 5) check($sformatf("rd%0d data", k), 32'(rd_data), 32'(1004 + k));
      check($sformatf("rd%0d bram_we", k), 32'(bram_we), 0);
      step();
    end
    idle();

    // Drain: detect_done collides with a request while two reads are in flight.
    cls_rd_req = 1; cls_rd_addr = 15'd7; #1;
    check("s0 gnt", 32'(gnt), 1);
    step();
    cls_rd_addr = 15'd8; #1;
    check("s1 gnt", 32'(gnt), 1);
    step();
    cls_rd_addr = 15'd9; detect_done = 1; #1;
    check("s2 gnt on done", 32'(gnt), 0);
    check("s2 state", 32'(state), 3);
    step();
    detect_done = 0; cls_rd_addr = 15'd12; cap_we = 1; #1;
    check("s3 state", 32'(state), 4);
    check("s3 gnt in drain", 32'(gnt), 0);
    check("s3 detect_en", 32'(detect_en), 0);
    check("s3 valid", 32'(valid), 1);
    check("s3 data", 32'(rd_data), 1007);
    check("s3 bram_addr", 32'(bram_addr), 8);
    step();
    idle();
    check("s4 state", 32'(state), 4);
    check("s4 valid", 32'(valid), 1);
    check("s4 data", 32'(rd_data), 1008);
    check("drain drop", 32'(drop), 7);
    step();
    check("s5 state", 32'(state), 0);
    check("s5 valid", 32'(valid), 0);

    // Stray cap_done / detect_done / go and an uncounted write while in ARM.
    cap_done = 1; cap_we = 1; go = 1; detect_done = 1;
    step();
    idle();
    check("arm stray pulses", 32'(state), 0);
    check("arm drop unchanged", 32'(drop), 7);
    check("sat drop held", 32'(s_drop), 3);

    // Reset mid-DETECT with two reads in flight.
    frame_start = 1;
    step();
    frame_start = 0;
    check("t1 capture", 32'(state), 1);
    cap_we = 1; cap_addr = 15'd10; cap_data = 20'd1010; cap_done = 1; go = 1;
    step();
    idle();
    check("t1 direct detect", 32'(state), 3);
    check("t1 last write", 32'(bram_din), 1010);
    cls_rd_req = 1; cls_rd_addr = 15'd7;
    step();
    cls_rd_addr = 15'd8;
    step();
    cls_rd_req = 0;
    rst = 1;
    #1;
    check("t1 rst state", 32'(state), 0);
    check("t1 rst bram_we", 32'(bram_we), 0);
    check("t1 rst bram_addr", 32'(bram_addr), 0);
    check("t1 rst bram_din", 32'(bram_din), 0);
    check("t1 rst detect_en", 32'(detect_en), 0);
    check("t1 rst drop", 32'(drop), 0);
    check("t1 rst drop sat", 32'(s_drop), 0);
    check("t1 rst valid", 32'(valid), 0);
    repeat (2) step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1 no stale valid", 32'(valid), 0);
      check("t1 stays arm", 32'(state), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
